mem_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-port, variable-latency instruction/data memory between the IF stage (instruction fetch) and the MEM stage (the load/store operations selected by the MemRead/MemWrite control bits). It serialises accesses and returns read data and a one-cycle ready pulse to each requester. It drives `stall_o` so the pipeline freezes and inserts no-ops while an access is outstanding. It also flags memory responses that never arrive.

---
 rtl/mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port, variable-latency memory between the
//            instruction-fetch port (IF) and the load/store port (DM).
//            Accesses are serialised. Each requester gets registered read
//            data and a one-cycle ready pulse. A combinational stall freezes
//            the pipeline while a request is outstanding. A sticky error flag
//            records memory responses that never arrived.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active low
//   if_req_i      fetch request (level, held until if_ready_o)
//   if_addr_i     fetch address
//   if_data_o     fetched instruction (registered)
//   if_ready_o    one-cycle fetch completion pulse
//   dm_read_i     load request
//   dm_write_i    store request (wins when dm_read_i is also high)
//   dm_addr_i     data address
//   dm_wdata_i    store data
//   dm_rdata_o    load data (registered, updated by loads only)
//   dm_ready_o    one-cycle data-port completion pulse
//   mem_enable_o  one-cycle command strobe to memory
//   mem_write_o   command is a write
//   mem_addr_o    latched command address
//   mem_data_o    latched write data
//   mem_data_i    memory read data, valid with mem_ack_i
//   mem_ack_i     memory completion
//   stall_o       pipeline freeze
//   err_o         sticky memory-timeout flag
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam int c_STREAK_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam int c_TCNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(STARVE_LIM);
    localparam logic [c_STREAK_W-1:0] c_STREAK_ONE = c_STREAK_W'(1);
    localparam logic [c_TCNT_W-1:0]   c_TCNT_LAST  = c_TCNT_W'(TIMEOUT - 1);
    localparam logic [c_TCNT_W-1:0]   c_TCNT_ONE   = c_TCNT_W'(1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ACC_IF  = 3'd1;
    localparam logic [2:0] c_ACC_DM  = 3'd2;
    localparam logic [2:0] c_RESP_IF = 3'd3;
    localparam logic [2:0] c_RESP_DM = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [c_STREAK_W-1:0] r_streak;
    logic [c_TCNT_W-1:0]   r_tcnt;
    logic                  r_mem_enable;
    logic                  r_mem_write;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_data;
    logic [DATA_W-1:0]     r_if_data;
    logic [DATA_W-1:0]     r_dm_rdata;
    logic                  r_err;

    logic w_dm_req;
    logic w_streak_full;
    logic w_in_acc;
    logic w_grant_if;
    logic w_grant_dm;
    logic w_capture;
    logic w_timeout;

    assign w_dm_req      = dm_read_i | dm_write_i;
    assign w_streak_full = (r_streak == c_STREAK_MAX);
    assign w_in_acc      = (r_state == c_ACC_IF) || (r_state == c_ACC_DM);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and per-cycle control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_dm  = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_IDLE: begin
                // The data port wins unless IF has already been passed over
                // STARVE_LIM times in a row.
                if (w_dm_req && !(if_req_i && w_streak_full)) begin
                    w_state_nxt = c_ACC_DM;
                    w_grant_dm  = 1'b1;
                end else if (if_req_i) begin
                    w_state_nxt = c_ACC_IF;
                    w_grant_if  = 1'b1;
                end
            end
            c_ACC_IF, c_ACC_DM: begin
                // A real ack on the final allowed cycle still counts as
                // a successful completion.
                if (mem_ack_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = (r_state == c_ACC_IF) ? c_RESP_IF : c_RESP_DM;
                end else if (r_tcnt == c_TCNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = (r_state == c_ACC_IF) ? c_RESP_IF : c_RESP_DM;
                end
            end
            c_RESP_IF, c_RESP_DM: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command latches, counters and response data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_streak     <= '0;
            r_tcnt       <= '0;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_if_data    <= '0;
            r_dm_rdata   <= '0;
            r_err        <= 1'b0;
        end else begin
            // Strobe is high exactly in the first ACC cycle.
            r_mem_enable <= w_grant_if | w_grant_dm;

            if (w_grant_dm) begin
                r_mem_addr  <= dm_addr_i;
                r_mem_data  <= dm_wdata_i;
                r_mem_write <= dm_write_i;
                r_tcnt      <= '0;
                if (!if_req_i) begin
                    r_streak <= '0;
                end else if (!w_streak_full) begin
                    r_streak <= r_streak + c_STREAK_ONE;
                end
            end else if (w_grant_if) begin
                r_mem_addr  <= if_addr_i;
                r_mem_write <= 1'b0;
                r_tcnt      <= '0;
                r_streak    <= '0;
            end else if (w_in_acc && (r_tcnt != c_TCNT_LAST)) begin
                r_tcnt <= r_tcnt + c_TCNT_ONE;
            end

            if (w_capture) begin
                if (r_state == c_ACC_IF) begin
                    r_if_data <= mem_data_i;
                end else if (!r_mem_write) begin
                    r_dm_rdata <= mem_data_i;
                end
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign if_ready_o   = (r_state == c_RESP_IF);
    assign dm_ready_o   = (r_state == c_RESP_DM);
    assign if_data_o    = r_if_data;
    assign dm_rdata_o   = r_dm_rdata;
    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign err_o        = r_err;
    assign stall_o      = (if_req_i & ~if_ready_o) | (w_dm_req & ~dm_ready_o);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Directed cycle-exact
//            scenarios, then randomized traffic from two requesters
//            against a memory responder with a transaction-level
//            reference model feeding per-port expectation queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_LIM = 3;
    localparam int TIMEOUT    = 4;
    localparam int N_TXN      = 40;

    logic              clk;
    logic              rst_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_ready_o;
    logic              dm_read_i;
    logic              dm_write_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ready_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic              stall_o;
    logic              err_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_LIM(STARVE_LIM),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_data_o   (if_data_o),
        .if_ready_o  (if_ready_o),
        .dm_read_i   (dm_read_i),
        .dm_write_i  (dm_write_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Power-on contents of every memory word not yet written.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    // Addresses in this window are never acknowledged by the memory.
    function automatic bit no_ack_addr(input logic [31:0] a);
        return (a[15:12] == 4'hF);
    endfunction

    // Physical memory seen by the responder, and the reference view
    // that the stimulus side updates when a transaction is issued.
    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] dev_read(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    typedef struct packed {
        logic        to;
        logic [31:0] data;
    } exp_t;

    exp_t ifq[$];
    exp_t dmq[$];

    bit sb_on    = 1'b0;
    bit auto_mem = 1'b0;
    bit seen_to  = 1'b0;

    logic [31:0] exp_if_reg;
    logic [31:0] exp_dm_reg;

    // ------------------------------------------------------------------
    // Scoreboard monitor: pops an expectation on every ready pulse
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_on) begin
            if (if_ready_o) begin
                if (ifq.size() == 0) begin
                    check("if_spurious_ready", 32'(if_ready_o), 32'd0);
                end else begin
                    e = ifq.pop_front();
                    if (e.to) seen_to = 1'b1;
                    check("sb_if_data", if_data_o, e.data);
                    check("sb_if_err", 32'(err_o), 32'(seen_to));
                end
            end
            if (dm_ready_o) begin
                if (dmq.size() == 0) begin
                    check("dm_spurious_ready", 32'(dm_ready_o), 32'd0);
                end else begin
                    e = dmq.pop_front();
                    if (e.to) seen_to = 1'b1;
                    check("sb_dm_rdata", dm_rdata_o, e.data);
                    check("sb_dm_err", 32'(err_o), 32'(seen_to));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory responder for the randomized phase
    // ------------------------------------------------------------------
    initial begin : responder
        forever begin
            @(negedge clk);
            if (auto_mem && mem_enable_o) begin : serve
                logic [31:0] a;
                int          d;
                a = mem_addr_o;
                if (!no_ack_addr(a)) begin
                    if (mem_write_o) dev_mem[a] = mem_data_o;
                    d = $urandom_range(0, 2);
                    repeat (d) @(negedge clk);
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_write_o ? 32'hBAD0BAD0 : dev_read(a);
                    @(negedge clk);
                    mem_ack_i  = 1'b0;
                    mem_data_i = $urandom;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        errors++;
        checks++;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        finish_run();
    end

    task automatic wait_enable(output bit ok);
        int w;
        w = 0;
        @(negedge clk); #1;
        while (!mem_enable_o && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        ok = mem_enable_o;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        bit          ok;
        logic [31:0] t3_exp;
        logic [31:0] prev_rd;

        rst_i      = 1'b0;
        if_req_i   = 1'b0;
        if_addr_i  = '0;
        dm_read_i  = 1'b0;
        dm_write_i = 1'b0;
        dm_addr_i  = '0;
        dm_wdata_i = '0;
        mem_data_i = '0;
        mem_ack_i  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_if_data", if_data_o, 32'd0);
        check("rst_dm_rdata", dm_rdata_o, 32'd0);
        check("rst_mem_enable", 32'(mem_enable_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);

        // Single IF fetch, ack one cycle after enable
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h40; #1;
        check("t1_c0_stall", 32'(stall_o), 32'd1);
        check("t1_c0_enable", 32'(mem_enable_o), 32'd0);
        @(negedge clk); #1;
        check("t1_c1_enable", 32'(mem_enable_o), 32'd1);
        check("t1_c1_addr", mem_addr_o, 32'h40);
        check("t1_c1_write", 32'(mem_write_o), 32'd0);
        check("t1_c1_stall", 32'(stall_o), 32'd1);
        @(negedge clk);
        mem_ack_i = 1'b1; mem_data_i = 32'h00500093; #1;
        check("t1_c2_enable", 32'(mem_enable_o), 32'd0);
        check("t1_c2_ready", 32'(if_ready_o), 32'd0);
        check("t1_c2_stall", 32'(stall_o), 32'd1);
        @(negedge clk);
        mem_ack_i = 1'b0; mem_data_i = '0; #1;
        check("t1_c3_ready", 32'(if_ready_o), 32'd1);
        check("t1_c3_data", if_data_o, 32'h00500093);
        check("t1_c3_stall", 32'(stall_o), 32'd0);
        if_req_i = 1'b0;
        @(negedge clk); #1;
        check("t1_c4_ready", 32'(if_ready_o), 32'd0);

        // Simultaneous IF and DM load: DM first, then IF
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h44;
        dm_read_i = 1'b1; dm_addr_i = 32'h80; #1;
        @(negedge clk); #1;
        check("t2_dm_enable", 32'(mem_enable_o), 32'd1);
        check("t2_dm_addr", mem_addr_o, 32'h80);
        mem_ack_i = 1'b1; mem_data_i = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack_i = 1'b0; mem_data_i = '0; #1;
        check("t2_dm_ready", 32'(dm_ready_o), 32'd1);
        check("t2_dm_rdata", dm_rdata_o, 32'hDEADBEEF);
        check("t2_if_not_ready", 32'(if_ready_o), 32'd0);
        check("t2_stall_if_waiting", 32'(stall_o), 32'd1);
        dm_read_i = 1'b0;
        @(negedge clk); #1;
        check("t2_idle_enable", 32'(mem_enable_o), 32'd0);
        @(negedge clk); #1;
        check("t2_if_enable", 32'(mem_enable_o), 32'd1);
        check("t2_if_addr", mem_addr_o, 32'h44);
        mem_ack_i = 1'b1; mem_data_i = 32'h11111111;
        @(negedge clk);
        mem_ack_i = 1'b0; mem_data_i = '0; #1;
        check("t2_if_ready", 32'(if_ready_o), 32'd1);
        check("t2_if_data", if_data_o, 32'h11111111);
        check("t2_dm_rdata_hold", dm_rdata_o, 32'hDEADBEEF);
        if_req_i = 1'b0;

        // Starvation: both ports held, IF granted after STARVE_LIM DM grants
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h48;
        dm_read_i = 1'b1; dm_addr_i = 32'h84;
        for (int g = 0; g < 2 * (STARVE_LIM + 1); g++) begin
            wait_enable(ok);
            t3_exp = ((g % (STARVE_LIM + 1)) == STARVE_LIM) ? 32'h48 : 32'h84;
            if (!ok) begin
                check("t3_grant_timeout", 32'(mem_enable_o), 32'd1);
            end else begin
                check("t3_grant_addr", mem_addr_o, t3_exp);
                mem_ack_i  = 1'b1;
                mem_data_i = (t3_exp == 32'h84) ? (32'hCAFE0000 + 32'(g)) : (32'h0BAD0000 + 32'(g));
                @(negedge clk);
                mem_ack_i = 1'b0; mem_data_i = '0;
            end
        end
        if_req_i = 1'b0; dm_read_i = 1'b0;
        prev_rd = 32'hCAFE0000 + 32'(2 * (STARVE_LIM + 1) - 2);
        #1;
        check("t3_last_load", dm_rdata_o, prev_rd);

        // Store with both read and write high
        @(negedge clk);
        dm_read_i = 1'b1; dm_write_i = 1'b1;
        dm_addr_i = 32'h10; dm_wdata_i = 32'h12345678;
        @(negedge clk); #1;
        check("t4_enable", 32'(mem_enable_o), 32'd1);
        check("t4_write", 32'(mem_write_o), 32'd1);
        check("t4_addr", mem_addr_o, 32'h10);
        check("t4_wdata", mem_data_o, 32'h12345678);
        mem_ack_i = 1'b1; mem_data_i = 32'hFFFF0000;
        @(negedge clk);
        mem_ack_i = 1'b0; mem_data_i = '0; #1;
        check("t4_ready", 32'(dm_ready_o), 32'd1);
        check("t4_rdata_unchanged", dm_rdata_o, prev_rd);
        dm_read_i = 1'b0; dm_write_i = 1'b0;

        // Timeout: no ack, ready and err in cycle TIMEOUT+1 after grant
        @(negedge clk);
        dm_read_i = 1'b1; dm_addr_i = 32'h20; #1;
        for (int c = 0; c <= TIMEOUT + 1; c++) begin
            if (c > 0) begin
                @(negedge clk); #1;
            end
            check("t5_ready", 32'(dm_ready_o), 32'(c == TIMEOUT + 1));
            check("t5_err", 32'(err_o), 32'(c == TIMEOUT + 1));
            if (c >= 1 && c <= TIMEOUT) begin
                check("t5_enable", 32'(mem_enable_o), 32'(c == 1));
                check("t5_addr_held", mem_addr_o, 32'h20);
            end
        end
        check("t5_rdata_unchanged", dm_rdata_o, prev_rd);
        dm_read_i = 1'b0;
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h4C;
        @(negedge clk); #1;
        check("t5_next_enable", 32'(mem_enable_o), 32'd1);
        mem_ack_i = 1'b1; mem_data_i = 32'h00000077;
        @(negedge clk);
        mem_ack_i = 1'b0; mem_data_i = '0; #1;
        check("t5_next_ready", 32'(if_ready_o), 32'd1);
        check("t5_next_data", if_data_o, 32'h00000077);
        check("t5_err_sticky", 32'(err_o), 32'd1);
        if_req_i = 1'b0;

        // Reset in the middle of an access
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h50;
        @(negedge clk); #1;
        check("t6_in_acc", 32'(mem_enable_o), 32'd1);
        rst_i = 1'b0; if_req_i = 1'b0; #1;
        check("t6_if_data", if_data_o, 32'd0);
        check("t6_dm_rdata", dm_rdata_o, 32'd0);
        check("t6_mem_enable", 32'(mem_enable_o), 32'd0);
        check("t6_mem_addr", mem_addr_o, 32'd0);
        check("t6_mem_data", mem_data_o, 32'd0);
        check("t6_err", 32'(err_o), 32'd0);
        check("t6_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b1; mem_ack_i = 1'b1; mem_data_i = 32'h99999999;
        @(negedge clk);
        mem_ack_i = 1'b0; mem_data_i = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t6_no_ready", 32'(if_ready_o), 32'd0);
            check("t6_data_zero", if_data_o, 32'd0);
            check("t6_no_enable", 32'(mem_enable_o), 32'd0);
            @(negedge clk);
        end

        // Randomized traffic against the reference model
        exp_if_reg = '0;
        exp_dm_reg = '0;
        seen_to    = 1'b0;
        sb_on      = 1'b1;
        auto_mem   = 1'b1;
        fork
            begin : if_driver
                logic [31:0] a;
                int          w;
                exp_t        e;
                for (int n = 0; n < N_TXN; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    a = 32'h1000 + ($urandom_range(0, 63) << 2);
                    if ($urandom_range(0, 15) == 0) a = 32'hF000 + ($urandom_range(0, 15) << 2);
                    e.to = no_ack_addr(a);
                    if (!e.to) exp_if_reg = init_word(a);
                    e.data = exp_if_reg;
                    ifq.push_back(e);
                    if_addr_i = a;
                    if_req_i  = 1'b1;
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!if_ready_o && w < 40);
                    check("if_latency_bound", 32'(if_ready_o), 32'd1);
                    if_req_i = 1'b0;
                end
            end
            begin : dm_driver
                logic [31:0] a;
                logic [31:0] wd;
                bit          wr;
                int          w;
                exp_t        e;
                for (int n = 0; n < N_TXN; n++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    a = 32'h2000 + ($urandom_range(0, 7) << 2);
                    if ($urandom_range(0, 15) == 0) a = 32'hF100 + ($urandom_range(0, 15) << 2);
                    wr = ($urandom_range(0, 2) == 1);
                    wd = $urandom;
                    e.to = no_ack_addr(a);
                    if (!e.to) begin
                        if (wr) ref_mem[a] = wd;
                        else    exp_dm_reg = ref_read(a);
                    end
                    e.data = exp_dm_reg;
                    dmq.push_back(e);
                    dm_addr_i  = a;
                    dm_wdata_i = wd;
                    dm_write_i = wr;
                    dm_read_i  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!dm_ready_o && w < 30);
                    check("dm_latency_bound", 32'(dm_ready_o), 32'd1);
                    dm_read_i  = 1'b0;
                    dm_write_i = 1'b0;
                end
            end
        join
        repeat (4) @(negedge clk);
        check("if_queue_drained", 32'(ifq.size()), 32'd0);
        check("dm_queue_drained", 32'(dmq.size()), 32'd0);
        finish_run();
    end

endmodule
`default_nettype wire
